// File: rtl/if_branch_ctrl_if.sv
// rtl/if_branch_ctrl_if.sv - fetch prediction and ID branch-resolution signal bundle
interface if_branch_ctrl_if;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic        br_valid;
    logic [31:0] br_pc;
    logic [31:0] br_target;
    logic [3:0]  br_op;
    logic        br_unsigned;
    logic        br_pred;
    logic [31:0] rs_a;
    logic [31:0] rs_b;
    logic        a_pending;
    logic        b_pending;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        resolved_taken;

    modport master (
        output fetch_pc, br_valid, br_pc, br_target, br_op, br_unsigned, br_pred,
               rs_a, rs_b, a_pending, b_pending,
        input  pred_taken, stall, flush, redirect_valid, redirect_pc, resolved_taken
    );

    modport slave (
        input  fetch_pc, br_valid, br_pc, br_target, br_op, br_unsigned, br_pred,
               rs_a, rs_b, a_pending, b_pending,
        output pred_taken, stall, flush, redirect_valid, redirect_pc, resolved_taken
    );
endinterface

// File: rtl/if_branch_ctrl.sv
// rtl/if_branch_ctrl.sv - branch resolution FSM, 2-bit BHT and branch statistics
module if_branch_ctrl #(
    parameter int IDX_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    if_branch_ctrl_if.slave  bus,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       bht [ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             cond_br;
    logic             pending;
    logic             lt;
    logic             taken;
    logic             mispredict;
    logic             stall_c;
    logic             resolve;
    logic             unused_fetch_bits;

    assign rd_idx            = bus.fetch_pc[IDX_W+1:2];
    assign upd_idx           = bus.br_pc[IDX_W+1:2];
    assign unused_fetch_bits = ^{bus.fetch_pc[31:IDX_W+2], bus.fetch_pc[1:0]};

    // Read is straight from the table registers, so a same-cycle update is not visible yet.
    assign bus.pred_taken = bht[rd_idx][1];

    assign cond_br = bus.br_valid & ~bus.br_op[3];
    assign pending = bus.a_pending | bus.b_pending;

    always_comb begin
        lt = bus.br_unsigned ? (bus.rs_a < bus.rs_b)
                             : ($signed(bus.rs_a) < $signed(bus.rs_b));
        case (bus.br_op[2:1])
            2'b00:   taken = (bus.rs_a == bus.rs_b);
            2'b01:   taken = (bus.rs_a != bus.rs_b);
            2'b10:   taken = lt;
            default: taken = ~lt;
        endcase
    end

    assign mispredict = taken ^ bus.br_pred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_WAIT: begin
                if (cond_br && pending) begin
                    state_nxt = S_WAIT;
                end else if (cond_br && mispredict) begin
                    state_nxt = S_REDIR;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The branch in ID during REDIR is being flushed, so it neither stalls nor resolves.
    always_comb begin
        stall_c = 1'b0;
        resolve = 1'b0;
        case (state)
            S_IDLE, S_WAIT: begin
                stall_c = cond_br & pending;
                resolve = cond_br & ~pending;
            end
            default: begin
                stall_c = 1'b0;
                resolve = 1'b0;
            end
        endcase
    end

    assign bus.stall = stall_c & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (resolve) begin
            if (taken && bht[upd_idx] != 2'b11) begin
                bht[upd_idx] <= bht[upd_idx] + 2'd1;
            end else if (!taken && bht[upd_idx] != 2'b00) begin
                bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.flush          <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= 32'd0;
            bus.resolved_taken <= 1'b0;
            branch_cnt         <= '0;
            mispred_cnt        <= '0;
        end else begin
            bus.flush          <= resolve & mispredict;
            bus.redirect_valid <= resolve & mispredict;
            if (resolve) begin
                bus.resolved_taken <= taken;
                if (branch_cnt != {CNT_W{1'b1}}) begin
                    branch_cnt <= branch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                if (mispredict) begin
                    bus.redirect_pc <= taken ? bus.br_target : bus.br_pc + 32'd4;
                    if (mispred_cnt != {CNT_W{1'b1}}) begin
                        mispred_cnt <= mispred_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_if_branch_ctrl.sv
// tb/tb_if_branch_ctrl.sv - self-checking bench for if_branch_ctrl
module tb_if_branch_ctrl;
    localparam int TB_CNT = 4;
    localparam int CMAX   = (1 << TB_CNT) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [TB_CNT-1:0] branch_cnt;
    logic [TB_CNT-1:0] mispred_cnt;

    if_branch_ctrl_if bus ();

    if_branch_ctrl #(.IDX_W(6), .CNT_W(TB_CNT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: counter values per table entry, plain integer counts.
    int          m_bht [64];
    int          m_bcnt;
    int          m_mcnt;
    bit          m_flush;
    bit          m_rtaken;
    logic [31:0] m_rpc;

    function automatic bit ref_taken(logic [3:0] op, bit uns, logic [31:0] a, logic [31:0] b);
        longint sa;
        longint sb;
        sa = uns ? longint'(a) : longint'($signed(a));
        sb = uns ? longint'(b) : longint'($signed(b));
        case (op[2:1])
            2'b00:   return a == b;
            2'b01:   return a != b;
            2'b10:   return sa < sb;
            default: return sa >= sb;
        endcase
    endfunction

    function automatic bit m_stall();
        return !m_flush && bus.br_valid && !bus.br_op[3] && (bus.a_pending || bus.b_pending);
    endfunction

    function automatic bit m_pred();
        return m_bht[bus.fetch_pc[7:2]] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        m_bcnt = 0; m_mcnt = 0; m_flush = 0; m_rtaken = 0; m_rpc = 32'd0;
    endtask

    task automatic model_edge();
        bit t;
        int idx;
        if (m_flush) begin
            m_flush = 0;
        end else if (bus.br_valid && !bus.br_op[3] && !(bus.a_pending || bus.b_pending)) begin
            t   = ref_taken(bus.br_op, bus.br_unsigned, bus.rs_a, bus.rs_b);
            idx = int'(bus.br_pc[7:2]);
            if (t) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else   m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
            m_rtaken = t;
            if (m_bcnt < CMAX) m_bcnt++;
            if (t != bus.br_pred) begin
                m_flush = 1;
                m_rpc   = t ? bus.br_target : bus.br_pc + 32'd4;
                if (m_mcnt < CMAX) m_mcnt++;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(bit v, logic [31:0] pc, logic [31:0] tgt, logic [3:0] op, bit uns,
                          bit pred, logic [31:0] a, logic [31:0] b, bit pa, bit pb);
        bus.br_valid = v; bus.br_pc = pc; bus.br_target = tgt; bus.br_op = op;
        bus.br_unsigned = uns; bus.br_pred = pred; bus.rs_a = a; bus.rs_b = b;
        bus.a_pending = pa; bus.b_pending = pb;
    endtask

    task automatic release_reset();
        set_br(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] pcs [3];
        pcs[0] = 32'h0; pcs[1] = 32'h100; pcs[2] = 32'hFC;
        rst_n = 1'b0;
        bus.fetch_pc = 32'h0;
        set_br(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checks++; if (branch_cnt !== 0) begin failures++; $display("FAIL reset_branch_cnt got %0d want 0", branch_cnt); end
        checks++; if (mispred_cnt !== 0) begin failures++; $display("FAIL reset_mispred_cnt got %0d want 0", mispred_cnt); end
        checks++; if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.stall !== 1'b0)
            begin failures++; $display("FAIL reset_ctrl got flush=%b rv=%b stall=%b want 0", bus.flush, bus.redirect_valid, bus.stall); end
        checks++; if (bus.redirect_pc !== 32'h0 || bus.resolved_taken !== 1'b0)
            begin failures++; $display("FAIL reset_regs got rpc=%h rt=%b want 0", bus.redirect_pc, bus.resolved_taken); end
        release_reset();
        for (int i = 0; i < 3; i++) begin
            bus.fetch_pc = pcs[i];
            #1;
            checks++; if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred pc=%h got %b want 0", pcs[i], bus.pred_taken); end
        end
    endtask

    task automatic test_beq_mispredict();
        set_br(1, 32'h40, 32'h80, 4'b0000, 0, 0, 32'd5, 32'd5, 0, 0);
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL beq_stall got %b want 0", bus.stall); end
        tick();
        checks++; if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b1)
            begin failures++; $display("FAIL beq_redirect got flush=%b rv=%b want 1", bus.flush, bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 32'h80) begin failures++; $display("FAIL beq_rpc got %h want 00000080", bus.redirect_pc); end
        checks++; if (mispred_cnt !== 1 || branch_cnt !== 1)
            begin failures++; $display("FAIL beq_counts got b=%0d m=%0d want 1 1", branch_cnt, mispred_cnt); end
        bus.br_valid = 0;
        bus.fetch_pc = 32'h40;
        #1;
        checks++; if (bus.pred_taken !== 1'b1) begin failures++; $display("FAIL beq_bht got %b want 1", bus.pred_taken); end
        tick();
        checks++; if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0)
            begin failures++; $display("FAIL beq_pulse_end got flush=%b rv=%b want 0", bus.flush, bus.redirect_valid); end
    endtask

    task automatic test_blt_signedness();
        set_br(1, 32'h200, 32'h300, 4'b0100, 0, 1, 32'hFFFF_FFFF, 32'd1, 0, 0);
        tick();
        checks++; if (bus.flush !== 1'b0 || bus.resolved_taken !== 1'b1)
            begin failures++; $display("FAIL blt_signed got flush=%b rt=%b want 0 1", bus.flush, bus.resolved_taken); end
        bus.br_unsigned = 1;
        tick();
        checks++; if (bus.flush !== 1'b1 || bus.resolved_taken !== 1'b0)
            begin failures++; $display("FAIL blt_unsigned got flush=%b rt=%b want 1 0", bus.flush, bus.resolved_taken); end
        checks++; if (bus.redirect_pc !== 32'h204) begin failures++; $display("FAIL blt_rpc got %h want 00000204", bus.redirect_pc); end
        bus.br_valid = 0;
        tick();
    endtask

    task automatic test_stall();
        int b0;
        b0 = m_bcnt;
        set_br(1, 32'h80, 32'h100, 4'b0010, 0, 1, 32'd1, 32'd2, 1, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL stall_cycle%0d got %b want 1", i, bus.stall); end
            tick();
        end
        bus.a_pending = 0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL stall_release got %b want 0", bus.stall); end
        tick();
        checks++; if (bus.flush !== 1'b0 || bus.resolved_taken !== 1'b1)
            begin failures++; $display("FAIL stall_resolve got flush=%b rt=%b want 0 1", bus.flush, bus.resolved_taken); end
        checks++; if (branch_cnt !== TB_CNT'(b0 + 1)) begin failures++; $display("FAIL stall_count got %0d want %0d", branch_cnt, b0 + 1); end
        bus.br_valid = 0;
        tick();
    endtask

    task automatic test_saturate();
        set_br(1, 32'h60, 32'h90, 4'b0000, 0, 1, 32'd7, 32'd7, 0, 0);
        bus.fetch_pc = 32'h60;
        #1;
        checks++; if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL sat_collision got %b want 0", bus.pred_taken); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (bus.pred_taken !== 1'b1 || m_bht[24] != 3)
            begin failures++; $display("FAIL sat_four got %b want 1", bus.pred_taken); end
        tick();
        checks++; if (bus.pred_taken !== 1'b1) begin failures++; $display("FAIL sat_fifth got %b want 1", bus.pred_taken); end
        bus.rs_b = 32'd8;
        tick();
        checks++; if (bus.flush !== 1'b1 || bus.pred_taken !== 1'b1)
            begin failures++; $display("FAIL sat_nt1 got flush=%b pred=%b want 1 1", bus.flush, bus.pred_taken); end
        bus.br_valid = 0;
        tick();
        bus.br_valid = 1; bus.br_pred = 0;
        tick();
        checks++; if (bus.flush !== 1'b0 || bus.pred_taken !== 1'b0)
            begin failures++; $display("FAIL sat_nt2 got flush=%b pred=%b want 0 0", bus.flush, bus.pred_taken); end
        bus.br_valid = 0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] vals [4];
        vals[0] = 32'd0; vals[1] = 32'd3; vals[2] = 32'h8000_0000; vals[3] = 32'hFFFF_FFFF;
        for (int n = 0; n < 400; n++) begin
            set_br($urandom_range(0, 9) < 7, 32'h1000 + ($urandom_range(0, 3) << 2),
                   $urandom, ($urandom_range(0, 4) == 0) ? 4'b1000 | 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 7)),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   vals[$urandom_range(0, 3)], vals[$urandom_range(0, 3)],
                   $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
            bus.fetch_pc = 32'h1000 + ($urandom_range(0, 3) << 2);
            #1;
            checks++; if (bus.stall !== m_stall()) begin failures++; $display("FAIL rnd_stall n=%0d got %b want %b", n, bus.stall, m_stall()); end
            checks++; if (bus.pred_taken !== m_pred()) begin failures++; $display("FAIL rnd_pred n=%0d got %b want %b", n, bus.pred_taken, m_pred()); end
            tick();
            checks++; if (bus.flush !== m_flush || bus.redirect_valid !== m_flush)
                begin failures++; $display("FAIL rnd_flush n=%0d got %b/%b want %b", n, bus.flush, bus.redirect_valid, m_flush); end
            checks++; if (bus.redirect_pc !== m_rpc) begin failures++; $display("FAIL rnd_rpc n=%0d got %h want %h", n, bus.redirect_pc, m_rpc); end
            checks++; if (bus.resolved_taken !== m_rtaken) begin failures++; $display("FAIL rnd_rt n=%0d got %b want %b", n, bus.resolved_taken, m_rtaken); end
            checks++; if (branch_cnt !== TB_CNT'(m_bcnt) || mispred_cnt !== TB_CNT'(m_mcnt))
                begin failures++; $display("FAIL rnd_cnt n=%0d got %0d/%0d want %0d/%0d", n, branch_cnt, mispred_cnt, m_bcnt, m_mcnt); end
        end
        bus.br_valid = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        set_br(1, 32'h40, 32'h80, 4'b0000, 0, 0, 32'd5, 32'd5, 0, 0);
        tick();
        bus.br_valid = 0;
        tick();
        set_br(1, 32'h44, 32'h88, 4'b0010, 0, 0, 32'd1, 32'd2, 0, 1);
        tick();
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL mid_wait_setup got %b want 1", bus.stall); end
        #2 rst_n = 1'b0;
        bus.fetch_pc = 32'h40;
        #1;
        checks++; if (bus.stall !== 1'b0 || bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0)
            begin failures++; $display("FAIL mid_wait_ctrl got stall=%b flush=%b rv=%b want 0", bus.stall, bus.flush, bus.redirect_valid); end
        checks++; if (branch_cnt !== 0 || mispred_cnt !== 0 || bus.pred_taken !== 1'b0)
            begin failures++; $display("FAIL mid_wait_state got b=%0d m=%0d pred=%b want 0", branch_cnt, mispred_cnt, bus.pred_taken); end
        release_reset();
        set_br(1, 32'h40, 32'h80, 4'b0000, 0, 0, 32'd5, 32'd5, 0, 0);
        tick();
        checks++; if (bus.flush !== 1'b1) begin failures++; $display("FAIL mid_redir_setup got %b want 1", bus.flush); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h0)
            begin failures++; $display("FAIL mid_redir_ctrl got flush=%b rv=%b rpc=%h want 0", bus.flush, bus.redirect_valid, bus.redirect_pc); end
        checks++; if (mispred_cnt !== 0 || bus.pred_taken !== 1'b0)
            begin failures++; $display("FAIL mid_redir_state got m=%0d pred=%b want 0", mispred_cnt, bus.pred_taken); end
        release_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_beq_mispredict();
        test_blt_signedness();
        test_stall();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
